// File: rtl/race_arbiter_bank.sv
// Bank of N_CH two-path race arbiters sharing one timeout and one result handshake.
// Each channel records which of its two finish signals rose first, or a tie / stuck condition.
module race_arbiter_bank #(
    parameter int unsigned N_CH    = 8,
    parameter int unsigned TMO_W   = 8,
    parameter bit          TIE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [TMO_W-1:0] tmo_limit,
    input  logic [N_CH-1:0]  finished1,
    input  logic [N_CH-1:0]  finished2,
    output logic             busy,
    output logic [N_CH-1:0]  resp,
    output logic [N_CH-1:0]  tie,
    output logic [N_CH-1:0]  stuck,
    output logic             timeout,
    output logic             resp_valid,
    input  logic             resp_ready
);

    localparam logic [N_CH-1:0] TIE_MASK = {N_CH{TIE_BIT}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RACE = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0]   decided_q, decided_d;
    logic [N_CH-1:0]   resp_q, resp_d;
    logic [N_CH-1:0]   tie_q, tie_d;
    logic [N_CH-1:0]   stuck_q, stuck_d;
    logic              timeout_q, timeout_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;

    logic [N_CH-1:0]   any_fin;
    logic [N_CH-1:0]   fresh;
    logic [N_CH-1:0]   fresh_tie;
    logic [N_CH-1:0]   fresh_p1;
    logic [N_CH-1:0]   dec_all;
    logic [TMO_W-1:0]  cnt_dec;

    // Per-channel decision terms for the current cycle
    always_comb begin
        any_fin   = finished1 | finished2;
        fresh     = ~decided_q & any_fin;
        fresh_tie = fresh & finished1 & finished2;
        fresh_p1  = fresh & finished1 & ~finished2;
        dec_all   = decided_q | fresh;
        cnt_dec   = (cnt_q == '0) ? '0 : cnt_q - TMO_W'(1);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-result logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        resp_d    = resp_q;
        tie_d     = tie_q;
        stuck_d   = stuck_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ARM;
                    cnt_d   = tmo_limit;
                end
            end
            ST_ARM: begin
                // A finish already high at arm cannot be raced; it is settled immediately
                stuck_d   = any_fin;
                decided_d = any_fin;
                resp_d    = any_fin & TIE_MASK;
                tie_d     = '0;
                timeout_d = 1'b0;
                state_d   = ST_RACE;
            end
            ST_RACE: begin
                resp_d    = resp_q | fresh_p1 | (fresh_tie & TIE_MASK);
                tie_d     = tie_q | fresh_tie;
                decided_d = dec_all;
                cnt_d     = cnt_dec;
                // Completion outranks a timeout landing in the same cycle
                if (&dec_all) begin
                    state_d = ST_DONE;
                end else if (cnt_dec == '0) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                    resp_d    = resp_q | fresh_p1 | (fresh_tie & TIE_MASK) | (~dec_all & TIE_MASK);
                    decided_d = '1;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        valid_d = (state_d == ST_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            decided_q <= '0;
            resp_q    <= '0;
            tie_q     <= '0;
            stuck_q   <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            resp_q    <= resp_d;
            tie_q     <= tie_d;
            stuck_q   <= stuck_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
        end
    end

    assign busy       = busy_q;
    assign resp       = resp_q;
    assign tie        = tie_q;
    assign stuck      = stuck_q;
    assign timeout    = timeout_q;
    assign resp_valid = valid_q;

endmodule

// File: tb/tb_race_arbiter_bank.sv
// Randomized self-checking bench for race_arbiter_bank; expectations come from per-channel
// finish times evaluated against the race rules.
module tb_race_arbiter_bank;

    localparam int N     = 8;
    localparam int TW    = 8;
    localparam bit TIE   = 1'b0;
    localparam int NEVER = 1000;

    logic          clk;
    logic          rst;
    logic          start;
    logic [TW-1:0] tmo_limit;
    logic [N-1:0]  finished1;
    logic [N-1:0]  finished2;
    logic          busy;
    logic [N-1:0]  resp;
    logic [N-1:0]  tie;
    logic [N-1:0]  stuck;
    logic          timeout;
    logic          resp_valid;
    logic          resp_ready;

    int total;
    int bad;

    // Rise time of each finish input, in RACE-cycle units (1 = first RACE cycle, <=0 = high before start)
    int t1 [N];
    int t2 [N];

    race_arbiter_bank #(.N_CH(N), .TMO_W(TW), .TIE_BIT(TIE)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .tmo_limit  (tmo_limit),
        .finished1  (finished1),
        .finished2  (finished2),
        .busy       (busy),
        .resp       (resp),
        .tie        (tie),
        .stuck      (stuck),
        .timeout    (timeout),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Level inputs for race cycle r (r=0 is the arm cycle, r<0 before start)
    task automatic drive(input int r);
        for (int i = 0; i < N; i++) begin
            finished1[i] = (t1[i] <= 0) || (r >= t1[i]);
            finished2[i] = (t2[i] <= 0) || (r >= t2[i]);
        end
    endtask

    // Launch one race, wait for the result, check it, then hold and acknowledge
    task automatic run_race(input string name, input int limit, input int hold, input bit poke);
        int d [N];
        int kall, l, k, lat;
        logic [N-1:0] er, et, es;
        logic eto;
        kall = 1; er = '0; et = '0; es = '0;
        for (int i = 0; i < N; i++) begin
            if (t1[i] <= 0 || t2[i] <= 0) begin
                es[i] = 1'b1;
                er[i] = TIE;
                d[i]  = 0;
            end else begin
                d[i] = (t1[i] < t2[i]) ? t1[i] : t2[i];
                if (d[i] > kall) kall = d[i];
            end
        end
        l   = (limit < 1) ? 1 : limit;
        eto = (kall > l);
        k   = eto ? l : kall;
        for (int i = 0; i < N; i++) begin
            if (!es[i]) begin
                if (d[i] > k)           er[i] = TIE;
                else if (t1[i] < t2[i]) er[i] = 1'b1;
                else if (t2[i] < t1[i]) er[i] = 1'b0;
                else begin er[i] = TIE; et[i] = 1'b1; end
            end
        end

        @(negedge clk);
        drive(-1);
        start = 1'b1;
        tmo_limit = TW'(limit);
        resp_ready = 1'b0;
        lat = -1;
        for (int c = 1; c <= k + 6 && lat < 0; c++) begin
            @(negedge clk);
            start = poke ? 1'($urandom) : 1'b0;
            if (resp_valid) lat = c;
            else begin
                drive(c - 1);
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL %s busy c=%0d got=%b want=1", name, c, busy);
                end
            end
        end
        start = 1'b0;
        total++;
        if (lat !== 2 + k) begin bad++; $display("FAIL %s latency got=%0d want=%0d", name, lat, 2 + k); end
        total++;
        if (resp !== er) begin bad++; $display("FAIL %s resp got=%h want=%h", name, resp, er); end
        total++;
        if (tie !== et) begin bad++; $display("FAIL %s tie got=%h want=%h", name, tie, et); end
        total++;
        if (stuck !== es) begin bad++; $display("FAIL %s stuck got=%h want=%h", name, stuck, es); end
        total++;
        if (timeout !== eto) begin bad++; $display("FAIL %s timeout got=%b want=%b", name, timeout, eto); end

        // Inputs and start churn while the consumer stalls; results must not move
        for (int h = 0; h < hold; h++) begin
            finished1 = N'($urandom);
            finished2 = N'($urandom);
            start = 1'($urandom);
            @(negedge clk);
            total++;
            if (resp_valid !== 1'b1 || resp !== er || tie !== et || stuck !== es || timeout !== eto) begin
                bad++;
                $display("FAIL %s hold h=%0d got v=%b r=%h t=%h s=%h to=%b want v=1 r=%h t=%h s=%h to=%b",
                         name, h, resp_valid, resp, tie, stuck, timeout, er, et, es, eto);
            end
        end
        start = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        total++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || resp !== er || timeout !== eto) begin
            bad++;
            $display("FAIL %s release got v=%b b=%b r=%h to=%b want v=0 b=0 r=%h to=%b",
                     name, resp_valid, busy, resp, timeout, er, eto);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; tmo_limit = '0; resp_ready = 1'b0;
        finished1 = '0; finished2 = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, resp, tie, stuck, timeout, resp_valid} !== '0) begin
            bad++;
            $display("FAIL reset got b=%b r=%h t=%h s=%h to=%b v=%b want all 0",
                     busy, resp, tie, stuck, timeout, resp_valid);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle busy got=%b want=0", busy); end
    endtask

    task automatic test_directed();
        for (int i = 0; i < N; i++) begin t1[i] = 3; t2[i] = 1; end
        t1[3] = 1; t2[3] = 3;
        run_race("path1_wins", 20, 2, 1'b0);
        total++;
        if (resp !== 8'h08) begin bad++; $display("FAIL path1_wins const got=%h want=08", resp); end

        for (int i = 0; i < N; i++) begin t1[i] = 1; t2[i] = 1; end
        run_race("all_tie", 20, 1, 1'b0);
        total++;
        if (tie !== 8'hFF) begin bad++; $display("FAIL all_tie const got=%h want=ff", tie); end

        for (int i = 0; i < N; i++) begin t1[i] = 1; t2[i] = 5; end
        t1[0] = NEVER; t2[0] = NEVER;
        run_race("timeout5", 5, 1, 1'b0);
        total++;
        if (resp !== 8'hFE || timeout !== 1'b1) begin
            bad++; $display("FAIL timeout5 const got r=%h to=%b want r=fe to=1", resp, timeout);
        end

        for (int i = 0; i < N; i++) begin t1[i] = 2 + (i % 3); t2[i] = 4 - (i % 3); end
        t1[5] = NEVER; t2[5] = 0;
        run_race("stuck5", 20, 1, 1'b0);
        total++;
        if (stuck !== 8'h20) begin bad++; $display("FAIL stuck5 const got=%h want=20", stuck); end

        for (int i = 0; i < N; i++) begin t1[i] = 1; t2[i] = 2; end
        t1[7] = 3; t2[7] = 3;
        run_race("last_at_limit", 3, 0, 1'b0);

        for (int i = 0; i < N; i++) begin t1[i] = 2; t2[i] = 2; end
        run_race("limit_zero", 0, 0, 1'b0);

        for (int i = 0; i < N; i++) begin t1[i] = 0; t2[i] = NEVER; end
        run_race("all_stuck", 4, 0, 1'b0);
    endtask

    task automatic test_handshake();
        for (int i = 0; i < N; i++) begin t1[i] = 1 + i; t2[i] = 8 - i; end
        run_race("handshake", 30, 10, 1'b1);
        for (int i = 0; i < N; i++) begin t1[i] = 2; t2[i] = 1; end
        run_race("restart", 30, 0, 1'b0);
    endtask

    task automatic test_reset_mid_race();
        for (int i = 0; i < N; i++) begin t1[i] = 1; t2[i] = 9; end
        t1[0] = NEVER; t2[0] = NEVER;
        @(negedge clk);
        drive(-1);
        start = 1'b1; tmo_limit = TW'(20); resp_ready = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            drive(c - 1);
        end
        @(negedge clk);
        drive(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({busy, resp, tie, stuck, timeout, resp_valid} !== '0) begin
            bad++;
            $display("FAIL mid_reset got b=%b r=%h t=%h s=%h to=%b v=%b want all 0",
                     busy, resp, tie, stuck, timeout, resp_valid);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if (resp_valid !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL mid_reset_quiet c=%0d got v=%b b=%b want 0", c, resp_valid, busy);
            end
        end
        for (int i = 0; i < N; i++) begin t1[i] = 3; t2[i] = 2; end
        t1[6] = 1;
        run_race("after_reset", 10, 1, 1'b0);
    endtask

    task automatic test_random();
        int lim;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N; i++) begin
                t1[i] = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 9));
                t2[i] = int'($urandom_range(1, 9));
                if ($urandom_range(0, 9) == 0) begin t1[i] = NEVER; t2[i] = NEVER; end
            end
            lim = int'($urandom_range(0, 10));
            run_race("random", lim, int'($urandom_range(0, 3)), 1'($urandom));
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        for (int i = 0; i < N; i++) begin t1[i] = NEVER; t2[i] = NEVER; end
        test_reset();
        test_directed();
        test_handshake();
        test_reset_mid_race();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
